// File: rtl/seq_player_pkg.sv
// Shared types and constants for the Simon sequence player.
// The speed-up option is selected with the SEQ_PLAYER_SPEEDUP_EN macro.
package seq_player_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GAP   = 2'd1,
      ST_FLASH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Every SPEEDUP_STEP items halves the durations, at most SPEEDUP_MAX_SHIFT times.
   localparam int SPEEDUP_STEP      = 4;
   localparam int SPEEDUP_MAX_SHIFT = 2;

   function automatic int speed_shift(input int len);
      int s;
      s = len / SPEEDUP_STEP;
      if (s > SPEEDUP_MAX_SHIFT) begin
         s = SPEEDUP_MAX_SHIFT;
      end else begin
         s = s;
      end
      return s;
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Load/decrement down-counter; expired while the count sits at zero.
module seq_timer #(
   parameter int TW = 4
) (
   input  logic          CLOCK_50,
   input  logic          resetn,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          expired
);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   // Next count: load wins, otherwise count down and hold at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != {TW{1'b0}}) begin
         count_d = count_q - TW'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         count_q <= {TW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == {TW{1'b0}});

endmodule

// File: rtl/seq_player.sv
// Simon sequence player: latches a pad sequence and flashes it one-hot with gaps.
// Optional per-level speed-up is enabled by defining SEQ_PLAYER_SPEEDUP_EN.
module seq_player
   import seq_player_pkg::*;
#(
   parameter int NUM_PADS     = 4,
   parameter int MAX_LEN      = 10,
   parameter int FLASH_CYCLES = 50_000_000,
   parameter int GAP_CYCLES   = 25_000_000,
   localparam int SYM_W  = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic                     CLOCK_50,
   input  logic                     resetn,
   input  logic                     start,
   input  logic                     abort,
   input  logic [LEN_W-1:0]         seq_len,
   input  logic [MAX_LEN*SYM_W-1:0] sequence_i,
   output logic [NUM_PADS-1:0]      flash,
   output logic [LEN_W-1:0]         step,
   output logic                     busy,
   output logic                     done
);

   localparam int MAX_DUR = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
   localparam int TW      = $clog2(MAX_DUR);

   state_e                   state_q, state_d;
   logic [LEN_W-1:0]         step_q, step_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [MAX_LEN*SYM_W-1:0] seq_q, seq_d;
   logic [NUM_PADS-1:0]      flash_q, flash_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic [LEN_W-1:0] len_clamp_s;
   logic [SYM_W-1:0] item_s;
   logic             load_s;
   logic [TW-1:0]    load_val_s;
   logic             expired_s;
   logic [TW-1:0]    f_cur_s, g_cur_s, f_new_s, g_new_s;

   assign len_clamp_s = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;

`ifdef SEQ_PLAYER_SPEEDUP_EN
   logic [TW-1:0] f_load_q, g_load_q;
   int            shift_s;

   // Durations are frozen at latch time from the clamped length.
   always_comb begin
      shift_s = speed_shift(int'(len_clamp_s));
      f_new_s = TW'((FLASH_CYCLES >> shift_s) - 1);
      g_new_s = TW'((GAP_CYCLES >> shift_s) - 1);
   end

   // Latched timer load values for the current playback.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         f_load_q <= {TW{1'b0}};
         g_load_q <= {TW{1'b0}};
      end else if (state_q == ST_IDLE && start && !abort) begin
         f_load_q <= f_new_s;
         g_load_q <= g_new_s;
      end else begin
         f_load_q <= f_load_q;
         g_load_q <= g_load_q;
      end
   end

   assign f_cur_s = f_load_q;
   assign g_cur_s = g_load_q;
`else
   assign f_new_s = TW'(FLASH_CYCLES - 1);
   assign g_new_s = TW'(GAP_CYCLES - 1);
   assign f_cur_s = f_new_s;
   assign g_cur_s = g_new_s;
`endif

   seq_timer #(.TW(TW)) u_timer (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .load     (load_s),
      .load_val (load_val_s),
      .expired  (expired_s)
   );

   // Next-state, latch and timer-load decisions.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      len_d      = len_q;
      seq_d      = seq_q;
      load_s     = 1'b0;
      load_val_s = {TW{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               seq_d  = sequence_i;
               len_d  = len_clamp_s;
               step_d = {LEN_W{1'b0}};
               if (len_clamp_s == {LEN_W{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_GAP;
                  load_s     = 1'b1;
                  load_val_s = g_new_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (expired_s) begin
               if (step_q < len_q) begin
                  state_d    = ST_FLASH;
                  load_s     = 1'b1;
                  load_val_s = f_cur_s;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_GAP;
            end
         end
         ST_FLASH: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (expired_s) begin
               step_d     = step_q + LEN_W'(1);
               state_d    = ST_GAP;
               load_s     = 1'b1;
               load_val_s = g_cur_s;
            end else begin
               state_d = ST_FLASH;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they come straight off flops.
   always_comb begin
      item_s = {SYM_W{1'b0}};
      for (int k = 0; k < MAX_LEN; k++) begin
         if (step_d == LEN_W'(k)) begin
            item_s = seq_d[k*SYM_W +: SYM_W];
         end else begin
            item_s = item_s;
         end
      end
      flash_d = {NUM_PADS{1'b0}};
      if (state_d == ST_FLASH && int'(item_s) < NUM_PADS) begin
         flash_d = NUM_PADS'(1) << item_s;
      end else begin
         flash_d = {NUM_PADS{1'b0}};
      end
      busy_d = (state_d == ST_GAP) || (state_d == ST_FLASH);
      done_d = (state_d == ST_DONE);
   end

   // State, latch and output registers.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         step_q  <= {LEN_W{1'b0}};
         len_q   <= {LEN_W{1'b0}};
         seq_q   <= {(MAX_LEN*SYM_W){1'b0}};
         flash_q <= {NUM_PADS{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         len_q   <= len_d;
         seq_q   <= seq_d;
         flash_q <= flash_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign flash = flash_q;
   assign step  = step_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player: timeline model plus directed literal checks.
module tb_seq_player;

   localparam int NP = 4;
   localparam int ML = 10;
   localparam int FC = 8;
   localparam int GC = 4;

   logic        CLOCK_50 = 1'b0;
   logic        resetn   = 1'b0;
   logic        start    = 1'b0;
   logic        abort    = 1'b0;
   logic [3:0]  seq_len  = 4'd0;
   logic [19:0] sequence_i = 20'd0;
   logic [3:0]  flash;
   logic [3:0]  step;
   logic        busy;
   logic        done;

   seq_player #(.NUM_PADS(NP), .MAX_LEN(ML), .FLASH_CYCLES(FC), .GAP_CYCLES(GC)) dut (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .start      (start),
      .abort      (abort),
      .seq_len    (seq_len),
      .sequence_i (sequence_i),
      .flash      (flash),
      .step       (step),
      .busy       (busy),
      .done       (done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // model of the current playback
   bit chk_en      = 1'b0;
   bit m_on        = 1'b0;
   int m_t0        = 0;
   int m_n         = 0;
   int m_f         = FC;
   int m_g         = GC;
   int m_abort_cyc = 32'h7fff_ffff;
   int m_prev_step = 0;
   int m_items[ML];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the timeline model.
   always @(negedge CLOCK_50) begin
      if (chk_en) begin
         int c, t, r, k, p, es;
         logic [3:0] ef;
         bit eb, ed;
         c = cyc - m_t0;
         ef = 4'd0; eb = 1'b0; ed = 1'b0; es = m_prev_step;
         if (m_on && c >= 1 && cyc <= m_abort_cyc) begin
            if (m_n == 0) begin
               ed = (c == 1);
               es = 0;
            end else begin
               t = m_n * (m_f + m_g) + m_g;
               if (c <= t) begin
                  eb = 1'b1;
                  r = c - 1;
                  k = r / (m_f + m_g);
                  p = r % (m_f + m_g);
                  es = k;
                  if (p >= m_g) ef = 4'd1 << m_items[k];
               end else begin
                  ed = (c == t + 1);
                  es = m_n;
               end
            end
         end else if (m_on && cyc > m_abort_cyc) begin
            es = -1;
         end
         chk("flash", 32'(flash), 32'(ef));
         chk("busy", 32'(busy), 32'(eb));
         chk("done", 32'(done), 32'(ed));
         if (es >= 0) chk("step", 32'(step), 32'(es));
      end
   end

   // Wait to the negedge inside cycle c of the current run.
   task automatic at_cycle(input int c);
      for (int i = 0; i < 300; i++) begin
         @(negedge CLOCK_50);
         if (cyc - m_t0 >= c) break;
      end
      if (cyc - m_t0 != c) chk("at_cycle_timeout", 32'(cyc - m_t0), 32'(c));
   endtask

   // Issue a start that the DUT will accept and arm the model.
   task automatic play(input int len, input logic [19:0] sq);
      int s;
      @(posedge CLOCK_50); #1;
      seq_len = 4'(len); sequence_i = sq; start = 1'b1;
      m_n = (len > ML) ? ML : len;
      s = 0;
`ifdef SEQ_PLAYER_SPEEDUP_EN
      s = ((m_n >> 2) > 2) ? 2 : (m_n >> 2);
`endif
      m_f = FC >> s; m_g = GC >> s;
      for (int k = 0; k < ML; k++) m_items[k] = int'(sq[k*2 +: 2]);
      m_t0 = cyc; m_abort_cyc = 32'h7fff_ffff; m_prev_step = -1; m_on = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0; seq_len = 4'($urandom); sequence_i = 20'($urandom);
   endtask

   // items 2,0,3 packed 2 bits each, item 0 lowest
   localparam logic [19:0] SEQ_A = 20'b00_00_00_00_00_00_00_11_00_10;

   initial begin
      #1;
      chk("rst_flash", 32'(flash), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_step", 32'(step), 32'd0);
      repeat (3) @(posedge CLOCK_50);
      #1 resetn = 1'b1;
      chk_en = 1'b1;

      // case 1: items 2,0,3
      play(3, SEQ_A);
      at_cycle(1);  chk("c1_busy1", 32'(busy), 32'd1);
      at_cycle(4);  chk("c1_flash4", 32'(flash), 32'd0);
      at_cycle(5);  chk("c1_flash5", 32'(flash), 32'b0100);
      at_cycle(12); chk("c1_flash12", 32'(flash), 32'b0100);
      at_cycle(13); chk("c1_flash13", 32'(flash), 32'd0);
      at_cycle(17); chk("c1_flash17", 32'(flash), 32'b0001);
      at_cycle(29); chk("c1_flash29", 32'(flash), 32'b1000);
      at_cycle(36); chk("c1_flash36", 32'(flash), 32'b1000);
      at_cycle(40); chk("c1_busy40", 32'(busy), 32'd1);
      at_cycle(41); chk("c1_done41", 32'(done), 32'd1);
                    chk("c1_busy41", 32'(busy), 32'd0);
      at_cycle(42); chk("c1_done42", 32'(done), 32'd0);

      // abort in idle blocks a coincident start
      @(posedge CLOCK_50); #1 start = 1'b1; abort = 1'b1; seq_len = 4'd2;
      @(posedge CLOCK_50); #1 start = 1'b0; abort = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      chk("blk_busy", 32'(busy), 32'd0);
      chk("blk_done", 32'(done), 32'd0);

      // case 2: length 0
      play(0, 20'hFFFFF);
      at_cycle(1); chk("c2_done1", 32'(done), 32'd1);
                   chk("c2_busy1", 32'(busy), 32'd0);
      at_cycle(3); chk("c2_done3", 32'(done), 32'd0);

      // case 3: length 13 clamps to 10
      play(13, 20'b11_10_01_00_11_10_01_00_11_10);
      at_cycle(124); chk("c3_busy124", 32'(busy), 32'd1);
      at_cycle(125); chk("c3_done125", 32'(done), 32'd1);
                     chk("c3_step125", 32'(step), 32'd10);
      at_cycle(127);

      // case 4: length 8 (speed-up shortens durations when enabled)
      play(8, 20'b00_00_01_10_11_00_01_10_11_01);
`ifdef SEQ_PLAYER_SPEEDUP_EN
      at_cycle(2);  chk("c4_flash2", 32'(flash), 32'b0010);
      at_cycle(26); chk("c4_done26", 32'(done), 32'd1);
      at_cycle(28);
`else
      at_cycle(5);   chk("c4_flash5", 32'(flash), 32'b0010);
      at_cycle(101); chk("c4_done101", 32'(done), 32'd1);
      at_cycle(103);
`endif

      // case 5: start mid-run ignored, abort mid-flash
      play(3, SEQ_A);
      at_cycle(2);
      @(posedge CLOCK_50); #1 start = 1'b1; seq_len = 4'd1; sequence_i = 20'd1;
      @(posedge CLOCK_50); #1 start = 1'b0;
      at_cycle(6);
      @(posedge CLOCK_50); #1 abort = 1'b1; m_abort_cyc = cyc;
      at_cycle(7);  chk("c5_flash7", 32'(flash), 32'b0100);
      @(posedge CLOCK_50); #1 abort = 1'b0;
      at_cycle(8);  chk("c5_flash8", 32'(flash), 32'd0);
                    chk("c5_busy8", 32'(busy), 32'd0);
      at_cycle(45); chk("c5_done45", 32'(done), 32'd0);

      // case 6: async reset mid-play, then a clean replay
      play(3, SEQ_A);
      at_cycle(9);
      @(posedge CLOCK_50); #1 resetn = 1'b0; m_on = 1'b0; m_prev_step = 0;
      #1;
      chk("c6_rst_flash", 32'(flash), 32'd0);
      chk("c6_rst_busy", 32'(busy), 32'd0);
      chk("c6_rst_step", 32'(step), 32'd0);
      @(posedge CLOCK_50); #1 resetn = 1'b1;
      play(3, SEQ_A);
      at_cycle(5);  chk("c6_flash5", 32'(flash), 32'b0100);
      at_cycle(41); chk("c6_done41", 32'(done), 32'd1);
      at_cycle(43);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_player.md
# seq_player

Parametrised Simon sequence player. On a `start` pulse it latches a stored sequence of pad indices and a length, then flashes each pad one-hot on `flash` for a programmable on-time, with an off-gap before, between and after flashes. It sits between the game controller, which owns the sequence and level, and the pad LED/HEX drivers. It supports a configurable pad count, sequence depth, handshake, abort, and an optional per-level speed-up.

## Interface
- `NUM_PADS`, 4: number of pads; `flash` width; `SYM_W = max(1, $clog2(NUM_PADS))`
- `MAX_LEN`, 10: maximum sequence length; `LEN_W = $clog2(MAX_LEN+1)`
- `FLASH_CYCLES`, 50_000_000: base flash on-time in clocks (≥4)
- `GAP_CYCLES`, 25_000_000: base gap time in clocks (≥4)
- `CLOCK_50`  in  1  system clock, all logic on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only when idle
- `abort`  in  1  synchronous cancel; dominates `start`
- `seq_len`  in  LEN_W  number of items to play; values above MAX_LEN are clamped to MAX_LEN
- `sequence`  in  MAX_LEN*SYM_W  item k is at `[k*SYM_W +: SYM_W]`; item 0 plays first
- `flash`  out  NUM_PADS  one-hot pad currently lit, else 0
- `step`  out  LEN_W  index of the item being flashed or awaited
- `busy`  out  1  high while playing
- `done`  out  1  one-cycle pulse at normal completion

## Operation
- States: IDLE, GAP, FLASH, DONE.
- IDLE, `start=1`, `abort=0`:
  - latch `sequence` and the clamped length, and clear `step`.
  - length 0 goes to DONE.
  - any other length goes to GAP with the timer loaded for G cycles.
- GAP:
  - on timer expiry, go to FLASH (load F) if `step` < length; otherwise go to DONE.
- FLASH:
  - on expiry, increment `step` and go to GAP (load G).
- DONE: lasts one cycle, then IDLE.
- `flash`:
  - is `1<<item[step]` only in FLASH; 0 in all other states.
  - an item ≥ NUM_PADS flashes as all-zero with unchanged timing.
- `busy`: 1 in GAP and FLASH; 0 in IDLE and DONE.
- `done`: 1 only in DONE.
- `start` while busy is ignored. Input changes after latching do not affect playback.
- `abort` in GAP, FLASH or DONE forces IDLE on the next edge, with no `done`. In IDLE it blocks a coincident `start`.
- Reset values: state IDLE, `flash=0`, `step=0`, `busy=0`, `done=0`, timer 0, latched registers 0.
- Reset mid-play returns to IDLE immediately and asynchronously.

## Timing
- F and G are the effective durations after optional speed-up; without it, F=FLASH_CYCLES and G=GAP_CYCLES.
- Cycle 0 is the cycle in which `start` is sampled high.
- GAP occupies cycles 1..G. Item k flashes for cycles G+1+k(F+G) .. G+k(F+G)+F.
- Exactly G dark cycles separate consecutive flashes. A trailing gap of G cycles follows the last flash.
- With N items, `done` is high in cycle N(F+G)+G+1; with N=0, in cycle 1.
- All outputs are registered state decodes; there is no combinational path from inputs to outputs.
- Timer is a down-counter of width `$clog2(max(FLASH_CYCLES,GAP_CYCLES))`. It loads duration−1 and expires at 0.

## Configuration
- `SEQ_PLAYER_SPEEDUP_EN` defined:
  - at latch time, s = min(len>>2, 2).
  - F = FLASH_CYCLES>>s and G = GAP_CYCLES>>s, both fixed for the whole playback.
- Not defined: s = 0 always, and the shift logic is absent.

## Structure
- Package `seq_player_pkg`: the state enum and the speed-up shift-limit constants (step 4, max shift 2).
- Sub-module `seq_timer`: load/decrement/expire down-counter, with ports `CLOCK_50`, `resetn`, `load`, `load_val`, `expired`.
- Top level: FSM, latch registers, one-hot decode.

## Test plan
Bench parameters: NUM_PADS=4, MAX_LEN=10, FLASH_CYCLES=8, GAP_CYCLES=4, speed-up off unless noted.

1. len=3, items 2,0,3 → `flash`=0100 in cycles 5–12, 0001 in 17–24, 1000 in 29–36; `done` in cycle 41; `busy` in cycles 1–40.
2. len=0 → `done` in cycle 1; `flash` stays 0; `busy` never high.
3. len=13 → clamped to 10 items; `done` in cycle 125; `step` reaches 10.
4. Speed-up on, len=8 → F=2, G=1; first flash in cycle 2; `done` in cycle 26.
5. `abort` in cycle 7 (mid-flash) → cycle 8 has `flash`=0 and `busy`=0; no `done`. A `start` in cycle 3 of a new run is ignored.
6. `resetn` low in cycle 10 → outputs are 0 immediately; a new `start` after release replays from item 0 with the case-1 timing.
